// File: rtl/round_ctrl.sv
// -----------------------------------------------------------------------------
// round_ctrl
//
// Round sequencer for the binary number game. Arms a round on start_i, draws
// an 8-bit target from a free-running LFSR, counts the per-round seconds
// budget down, turns the guess button into a one-cycle pulse and reports the
// held compare / timeout flags back to the game logic.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   btn_i        debounced, clk-synchronous guess button level
//   sw_i[7:0]    player's binary guess
//   start_i      one-cycle pulse arming a new round (also restarts a live one)
//   secs_i[4:0]  seconds budget, sampled only with start_i (clamped to >= 3)
//   guess_p      one-cycle pulse per btn_i rising edge, in every state
//   target_o     current round target, never 0 once a round has been armed
//   secs_left_o  remaining seconds of the current round
//   cmp_r        held result of the last in-round guess (1 = match)
//   end_f        held high once the round timer has expired
//   busy_o       high while a round is running
// -----------------------------------------------------------------------------
module round_ctrl #(
    parameter int         TICK_CYCLES = 50_000_000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    input  logic [7:0] sw_i,
    input  logic       start_i,
    input  logic [4:0] secs_i,
    output logic       guess_p,
    output logic [7:0] target_o,
    output logic [4:0] secs_left_o,
    output logic       cmp_r,
    output logic       end_f,
    output logic       busy_o
);

    // A single-cycle tick would need a zero-width counter; keep at least 1 bit.
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      lfsr_q;
    logic [7:0]      lfsr_d;
    logic [PW-1:0]   pre_q;
    logic            btn_q;
    logic            rise;
    logic [7:0]      arm_target;
    logic [4:0]      arm_secs;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign rise = btn_i & ~btn_q;

    // A zero LFSR value would make the target indistinguishable from "no round".
    assign arm_target = (lfsr_q == 8'd0) ? 8'd1 : lfsr_q;
    assign arm_secs   = (secs_i < 5'd3) ? 5'd3 : secs_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            pre_q       <= '0;
            btn_q       <= 1'b0;
            guess_p     <= 1'b0;
            target_o    <= 8'd0;
            secs_left_o <= 5'd0;
            cmp_r       <= 1'b0;
            end_f       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            btn_q   <= btn_i;
            // The pulse is independent of the FSM; only its effect on cmp_r is gated.
            guess_p <= rise;

            if (start_i) begin
                // Arming takes priority over a coincident button rise.
                state_q     <= RUN;
                target_o    <= arm_target;
                secs_left_o <= arm_secs;
                pre_q       <= '0;
                cmp_r       <= 1'b0;
                end_f       <= 1'b0;
                busy_o      <= 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (rise) begin
                            // A guess on the final tick still wins over the timeout.
                            cmp_r   <= (sw_i == target_o);
                            state_q <= DONE;
                            busy_o  <= 1'b0;
                        end else if (pre_q == PRE_LAST) begin
                            pre_q <= '0;
                            if (secs_left_o <= 5'd1) begin
                                secs_left_o <= 5'd0;
                                end_f       <= 1'b1;
                                state_q     <= TIMEOUT;
                                busy_o      <= 1'b0;
                            end else begin
                                secs_left_o <= secs_left_o - 5'd1;
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                    default: begin
                        // IDLE, DONE and TIMEOUT hold everything until the next arm.
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Round sequencer for the binary number game. Sits between the game-logic FSM and the play datapath: it arms a round on request, draws a fresh 8-bit target from a free-running LFSR, and counts down the per-round seconds budget. It converts the player's button press into a one-cycle guess pulse, compares the switches against the target, and returns the held `cmp_r` / `end_f` flags the game logic consumes.

## Interface
- `TICK_CYCLES`, 50_000_000: clk cycles per one-second tick (benches use 4).
- `LFSR_SEED`, 8'hA5: LFSR value loaded on reset; must be nonzero.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_i` input 1: debounced, clk-synchronous guess button level.
- `sw_i` input 8: player's binary guess from switches.
- `start_i` input 1: one-cycle pulse that arms a new round.
- `secs_i` input 5: seconds budget, sampled only on `start_i`.
- `guess_p` output 1: one-cycle pulse per `btn_i` rising edge, in any FSM state.
- `target_o` output 8: current round target; never 0 after the first start.
- `secs_left_o` output 5: remaining seconds.
- `cmp_r` output 1: held result of the last in-round guess (1 = `sw_i == target_o`).
- `end_f` output 1: held high once the timer expires.
- `busy_o` output 1: high while in RUN.

## Operation
- FSM states: IDLE(0), RUN(1), DONE(2), TIMEOUT(3).
- IDLE → RUN on `start_i`.
- RUN → DONE on a button rising edge.
- RUN → TIMEOUT when the final tick takes `secs_left_o` to 0.
- DONE or TIMEOUT → RUN on `start_i`.
- `start_i` during RUN restarts the round: new target, reload, flags cleared.
- Arm action, at the edge where `start_i` = 1:
  - `target_o` ← LFSR value; if the LFSR value is 0, load 1.
  - `secs_left_o` ← max(`secs_i`, 3).
  - Prescaler ← 0.
  - `cmp_r` ← 0, `end_f` ← 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0. Advances every cycle in all states except reset.
- Prescaler: counts 0..`TICK_CYCLES`−1 in RUN only. At terminal count it wraps to 0 and `secs_left_o` decrements by 1. Held in other states.
- Button edge: `btn_q` is `btn_i` registered; rise = `btn_i` & ~`btn_q`. `guess_p` is the registered rise.
- On a rise while in RUN: `cmp_r` ← (`sw_i` == `target_o`) and the FSM goes to DONE. `secs_left_o` freezes.
- Rises outside RUN only pulse `guess_p`; `cmp_r` and the FSM are unchanged.
- Timeout: the tick with `secs_left_o` == 1 sets `secs_left_o` ← 0 and `end_f` ← 1, and the FSM goes to TIMEOUT.
- `end_f` and `cmp_r` hold until the next arm or reset.
- Simultaneous final tick and button rise: the guess wins. `cmp_r` is evaluated, FSM → DONE, `end_f` stays 0, `secs_left_o` stays 1.
- Simultaneous `start_i` and button rise: the arm wins and the guess is ignored (`guess_p` still pulses).
- Reset values: `guess_p`, `target_o`, `secs_left_o`, `cmp_r`, `end_f`, `busy_o` = 0; FSM = IDLE; LFSR = `LFSR_SEED`; prescaler = 0; `btn_q` = 0.
- Reset mid-round aborts immediately to these values.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start_i` sampled at edge k:
  - `busy_o`, `target_o`, `secs_left_o` = N valid after edge k.
  - Decrements occur at edges k+T, k+2T, …, where T = `TICK_CYCLES`.
  - `end_f` rises at edge k+N·T, and `busy_o` falls at the same edge.
- `btn_i` first sampled high at edge j: `guess_p` high for exactly the cycle after edge j.
- `cmp_r` and the DONE transition update at the same edge j.
- Holding `btn_i` high produces only one pulse.
- Arithmetic: `secs_left_o` never underflows. The prescaler width is ceil(log2(`TICK_CYCLES`)).

## Test plan
- Reset: assert `rst` for 2 cycles with `btn_i` toggling → all outputs 0. After release with no `start_i`, `busy_o` stays 0 for 50 cycles.
- Timeout (T=4, `secs_i`=5, no button): `secs_left_o` steps 5,4,3,2,1,0 at 4-cycle intervals. `end_f`=1 and `busy_o`=0 exactly 20 cycles after the start edge; `cmp_r`=0.
- Correct guess: start `secs_i`=5, set `sw_i`=`target_o`, raise `btn_i` 6 cycles later → single `guess_p` pulse, `cmp_r`=1, `secs_left_o` frozen at 4, `end_f` stays 0 indefinitely.
- Wrong guess then re-arm: `sw_i`=`target_o`^8'h01, press → `cmp_r`=0, DONE. Next `start_i` → `cmp_r`=0, new nonzero `target_o`, `busy_o`=1.
- Clamp and race: `secs_i`=1 → `secs_left_o`=3. A button rise aligned with the edge at start+12 gives `cmp_r` evaluated, `end_f`=0, `secs_left_o`=1.
- Reset mid-RUN at `secs_left_o`=2 → all outputs 0 next cycle, FSM IDLE. A following `start_i` with `secs_i`=4 times out after 16 cycles.
